// File: rtl/nios_oci_trace_monitor_if.sv
// Trace-capture and history-drain signals shared between the trace source/reader
// and the OCI trace monitor.
interface nios_oci_trace_monitor_if #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4
) ();
    logic                    arm;
    logic                    dct_valid;
    logic [DATA_W-1:0]       dct_buffer;
    logic [CNT_W-1:0]        dct_count;
    logic                    test_ending;
    logic                    test_has_ended;
    logic                    rd_ready;
    logic                    rd_valid;
    logic [CNT_W+DATA_W-1:0] rd_data;

    modport master (
        output arm, dct_valid, dct_buffer, dct_count,
        output test_ending, test_has_ended, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  arm, dct_valid, dct_buffer, dct_count,
        input  test_ending, test_has_ended, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/nios_oci_trace_monitor.sv
// Circular data-trace history with trigger/post-trigger window and hard stop;
// the frozen history is drained oldest-first over a valid/ready port.
module nios_oci_trace_monitor #(
    parameter int DATA_W    = 30,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    nios_oci_trace_monitor_if.slave  bus,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     wrapped,
    output logic [31:0]              total_words,
    output logic                     done,
    output logic [1:0]               state
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = CNT_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_FROZEN  = 2'd3
    } state_t;

    state_t          state_r, state_next_s;
    logic [AW:0]     post_cnt_r, post_next_s;
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [AW:0]     fill_r;
    logic            wrapped_r, done_r;
    logic [31:0]     total_r;
    logic [EW-1:0]   mem_r [DEPTH];
    logic [EW-1:0]   rd_hold_r;
    logic            store_s, pop_s, full_s, frozen_s;

    // Store/pop qualification; arm suppresses both in its own cycle
    always_comb begin
        frozen_s = (state_r == ST_FROZEN);
        full_s   = (fill_r == (AW+1)'(DEPTH));
        store_s  = !bus.arm && bus.dct_valid && (bus.dct_count != {CNT_W{1'b0}}) &&
                   ((state_r == ST_CAPTURE) || (state_r == ST_POST));
        pop_s    = !bus.arm && frozen_s && (fill_r != {(AW+1){1'b0}}) && bus.rd_ready;
    end

    // Next-state logic: arm beats hard stop, hard stop beats trigger
    always_comb begin
        state_next_s = state_r;
        post_next_s  = post_cnt_r;
        if (bus.arm) begin
            state_next_s = ST_CAPTURE;
            post_next_s  = {(AW+1){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = ST_IDLE;
                ST_CAPTURE: begin
                    if (bus.test_has_ended) begin
                        state_next_s = ST_FROZEN;
                    end else if (bus.test_ending) begin
                        if (POST_TRIG == 0) begin
                            state_next_s = ST_FROZEN;
                        end else begin
                            state_next_s = ST_POST;
                            post_next_s  = (AW+1)'(POST_TRIG);
                        end
                    end else begin
                        state_next_s = ST_CAPTURE;
                    end
                end
                ST_POST: begin
                    if (bus.test_has_ended) begin
                        state_next_s = ST_FROZEN;
                    end else if (store_s) begin
                        post_next_s = post_cnt_r - {{AW{1'b0}}, 1'b1};
                        if (post_cnt_r == {{AW{1'b0}}, 1'b1}) begin
                            state_next_s = ST_FROZEN;
                        end else begin
                            state_next_s = ST_POST;
                        end
                    end else begin
                        state_next_s = ST_POST;
                    end
                end
                ST_FROZEN: state_next_s = ST_FROZEN;
                default:   state_next_s = ST_IDLE;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            post_cnt_r <= {(AW+1){1'b0}};
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            post_cnt_r <= post_next_s;
            done_r     <= (state_next_s == ST_FROZEN);
        end
    end

    // Pointers, occupancy and statistics; a store into a full buffer drops the oldest entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            fill_r    <= {(AW+1){1'b0}};
            wrapped_r <= 1'b0;
            total_r   <= 32'd0;
        end else if (bus.arm) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            fill_r    <= {(AW+1){1'b0}};
            wrapped_r <= 1'b0;
            total_r   <= 32'd0;
        end else if (store_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (full_s) begin
                rd_ptr_r  <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                wrapped_r <= 1'b1;
            end else begin
                fill_r <= fill_r + {{AW{1'b0}}, 1'b1};
            end
            if (total_r != 32'hFFFF_FFFF) begin
                total_r <= total_r + 32'd1;
            end
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            fill_r   <= fill_r - {{AW{1'b0}}, 1'b1};
        end
    end

    // History array; contents need no reset
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= {bus.dct_count, bus.dct_buffer};
        end
    end

    // Keeps the last presented entry visible once the buffer leaves FROZEN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_hold_r <= {EW{1'b0}};
        end else if (frozen_s) begin
            rd_hold_r <= mem_r[rd_ptr_r];
        end else begin
            rd_hold_r <= rd_hold_r;
        end
    end

    assign bus.rd_valid = frozen_s && (fill_r != {(AW+1){1'b0}});
    assign bus.rd_data  = frozen_s ? mem_r[rd_ptr_r] : rd_hold_r;
    assign fill_level   = fill_r;
    assign wrapped      = wrapped_r;
    assign total_words  = total_r;
    assign done         = done_r;
    assign state        = state_r;
endmodule

// File: tb/tb_nios_oci_trace_monitor.sv
// Bench for nios_oci_trace_monitor: directed scenarios plus randomized traffic
// checked against a queue-based history model.
module tb_nios_oci_trace_monitor;
    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 8;
    localparam int PT     = 2;
    localparam int EW     = CNT_W + DATA_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nios_oci_trace_monitor_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    nios_oci_trace_monitor_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus0 ();

    logic [3:0]  fill_level, fill0;
    logic        wrapped, wrapped0, done, done0;
    logic [31:0] total_words, total0;
    logic [1:0]  state, state0;

    nios_oci_trace_monitor #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .POST_TRIG(PT)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .fill_level(fill_level),
        .wrapped(wrapped), .total_words(total_words), .done(done), .state(state));

    nios_oci_trace_monitor #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .fill_level(fill0),
        .wrapped(wrapped0), .total_words(total0), .done(done0), .state(state0));

    assign bus0.arm            = bus.arm;
    assign bus0.dct_valid      = bus.dct_valid;
    assign bus0.dct_buffer     = bus.dct_buffer;
    assign bus0.dct_count      = bus.dct_count;
    assign bus0.test_ending    = bus.test_ending;
    assign bus0.test_has_ended = bus.test_has_ended;
    assign bus0.rd_ready       = bus.rd_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: phase 0 idle, 1 capturing, 2 post-trigger, 3 frozen
    logic [EW-1:0] m_q[$];
    logic [31:0]   m_total;
    logic          m_wrapped;
    int            m_phase;
    int            m_rem;

    task automatic model_reset();
        m_q.delete(); m_total = 32'd0; m_wrapped = 1'b0; m_phase = 0; m_rem = 0;
    endtask

    task automatic model_update();
        bit storing;
        if (bus.arm) begin
            m_q.delete(); m_total = 32'd0; m_wrapped = 1'b0; m_phase = 1;
        end else begin
            storing = (m_phase == 1 || m_phase == 2) && bus.dct_valid && (bus.dct_count != 4'd0);
            if (m_phase == 3 && bus.rd_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (storing) begin
                m_q.push_back({bus.dct_count, bus.dct_buffer});
                if (m_q.size() > DEPTH) begin
                    void'(m_q.pop_front());
                    m_wrapped = 1'b1;
                end
                if (m_total != 32'hFFFF_FFFF) m_total = m_total + 32'd1;
            end
            if (m_phase == 1) begin
                if (bus.test_has_ended) m_phase = 3;
                else if (bus.test_ending) begin
                    m_phase = (PT == 0) ? 3 : 2;
                    m_rem = PT;
                end
            end else if (m_phase == 2) begin
                if (bus.test_has_ended) m_phase = 3;
                else if (storing) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_phase = 3;
                end
            end
        end
    endtask

    task automatic step(input logic a, input logic v, input logic [DATA_W-1:0] b,
                        input logic [CNT_W-1:0] c, input logic te, input logic he,
                        input logic rr);
        bus.arm = a; bus.dct_valid = v; bus.dct_buffer = b; bus.dct_count = c;
        bus.test_ending = te; bus.test_has_ended = he; bus.rd_ready = rr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.arm = 1'b0; bus.dct_valid = 1'b0; bus.dct_buffer = '0; bus.dct_count = '0;
        bus.test_ending = 1'b0; bus.test_has_ended = 1'b0; bus.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (state !== 2'd0 || fill_level !== 4'd0 || total_words !== 32'd0 || done !== 1'b0 ||
            wrapped !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_values: state=%0d fill=%0d total=%0d done=%b wrapped=%b rd_valid=%b rd_data=%h, required all zero",
                     state, fill_level, total_words, done, wrapped, bus.rd_valid, bus.rd_data);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 30'(i + 1), 4'd3, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (state !== 2'd0 || fill_level !== 4'd0 || total_words !== 32'd0 || bus.rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_no_store: state=%0d fill=%0d total=%0d rd_valid=%b, required 0/0/0/0",
                     state, fill_level, total_words, bus.rd_valid);
        end
    endtask

    task automatic drain_expect(input string name, input int first, input int last, input logic [3:0] cnt);
        for (int k = first; k <= last; k++) begin
            n_checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== {cnt, 30'(k)}) begin
                n_errors++;
                $display("FAIL %s_drain: rd_valid=%b rd_data=%h, required 1 and %h",
                         name, bus.rd_valid, bus.rd_data, {cnt, 30'(k)});
            end
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
        n_checks++;
        if (bus.rd_valid !== 1'b0 || done !== 1'b1 || state !== 2'd3 || fill_level !== 4'd0) begin
            n_errors++;
            $display("FAIL %s_empty: rd_valid=%b done=%b state=%0d fill=%0d, required 0/1/3/0",
                     name, bus.rd_valid, done, state, fill_level);
        end
    endtask

    task automatic test_basic();
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 30'(i), 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 30'd6, 4'd1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state !== 2'd3 || fill_level !== 4'd6 || wrapped !== 1'b0 || done !== 1'b1 || total_words !== 32'd6) begin
            n_errors++;
            $display("FAIL basic_freeze: state=%0d fill=%0d wrapped=%b done=%b total=%0d, required 3/6/0/1/6",
                     state, fill_level, wrapped, done, total_words);
        end
        drain_expect("basic", 1, 6, 4'd1);
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) step(1'b0, 1'b1, 30'(i), 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (fill_level !== 4'd8 || wrapped !== 1'b1 || total_words !== 32'd20 || state !== 2'd3) begin
            n_errors++;
            $display("FAIL wrap_freeze: fill=%0d wrapped=%b total=%0d state=%0d, required 8/1/20/3",
                     fill_level, wrapped, total_words, state);
        end
        drain_expect("wrap", 13, 20, 4'd1);
    endtask

    task automatic test_post_trigger();
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 30'(i), 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 30'd5, 4'd1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (state !== 2'd2 || state0 !== 2'd3 || fill0 !== 4'd5 || total0 !== 32'd5) begin
            n_errors++;
            $display("FAIL post_trigger_cycle: state=%0d state_pt0=%0d fill_pt0=%0d total_pt0=%0d, required 2/3/5/5",
                     state, state0, fill0, total0);
        end
        step(1'b0, 1'b1, 30'd6, 4'd1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (state !== 2'd2) begin
            n_errors++;
            $display("FAIL post_window: state=%0d, required 2", state);
        end
        step(1'b0, 1'b1, 30'd7, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 30'd8, 4'd1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (state !== 2'd3 || fill_level !== 4'd7 || total_words !== 32'd7 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL post_freeze: state=%0d fill=%0d total=%0d done=%b, required 3/7/7/1",
                     state, fill_level, total_words, done);
        end
        drain_expect("post", 1, 7, 4'd1);
    endtask

    task automatic test_filter_priority();
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 30'd99, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 30'd98, 4'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 30'd7, 4'd2, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fill_level !== 4'd1 || total_words !== 32'd1) begin
            n_errors++;
            $display("FAIL filter: fill=%0d total=%0d, required 1/1", fill_level, total_words);
        end
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (state !== 2'd3 || bus.rd_data !== {4'd2, 30'd7}) begin
            n_errors++;
            $display("FAIL both_triggers: state=%0d rd_data=%h, required 3 and %h", state, bus.rd_data, {4'd2, 30'd7});
        end
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state !== 2'd1 || fill_level !== 4'd0 || total_words !== 32'd0 || done !== 1'b0 || bus.rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL arm_beats_stop: state=%0d fill=%0d total=%0d done=%b rd_valid=%b, required 1/0/0/0/0",
                     state, fill_level, total_words, done, bus.rd_valid);
        end
    endtask

    task automatic test_disruption();
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 30'(i), 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (fill_level !== 4'd4 || bus.rd_data !== {4'd5, 30'd3}) begin
            n_errors++;
            $display("FAIL toggled_drain: fill=%0d rd_data=%h, required 4 and %h", fill_level, bus.rd_data, {4'd5, 30'd3});
        end
        step(1'b1, 1'b1, 30'd50, 4'd1, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (fill_level !== 4'd0 || bus.rd_valid !== 1'b0 || state !== 2'd1 || total_words !== 32'd0) begin
            n_errors++;
            $display("FAIL arm_mid_drain: fill=%0d rd_valid=%b state=%0d total=%0d, required 0/0/1/0",
                     fill_level, bus.rd_valid, state, total_words);
        end
        step(1'b0, 1'b1, 30'd42, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 30'd43, 4'd1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (state !== 2'd2 || fill_level !== 4'd2) begin
            n_errors++;
            $display("FAIL restart_capture: state=%0d fill=%0d, required 2/2", state, fill_level);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (state !== 2'd0 || fill_level !== 4'd0 || total_words !== 32'd0 || done !== 1'b0 ||
            wrapped !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 34'd0) begin
            n_errors++;
            $display("FAIL async_reset: state=%0d fill=%0d total=%0d done=%b wrapped=%b rd_valid=%b rd_data=%h, required all zero",
                     state, fill_level, total_words, done, wrapped, bus.rd_valid, bus.rd_data);
        end
        idle_inputs();
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] cnt;
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cnt = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 30'($urandom), cnt,
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 69) == 0), 1'($urandom));
            n_checks++;
            if (state !== 2'(m_phase) || fill_level !== 4'(m_q.size()) || total_words !== m_total ||
                wrapped !== m_wrapped || done !== (m_phase == 3) ||
                bus.rd_valid !== (m_phase == 3 && m_q.size() > 0)) begin
                n_errors++;
                $display("FAIL random_status cycle %0d: state=%0d fill=%0d total=%0d wrapped=%b done=%b rd_valid=%b, required %0d/%0d/%0d/%b/%b/%b",
                         i, state, fill_level, total_words, wrapped, done, bus.rd_valid, m_phase, m_q.size(),
                         m_total, m_wrapped, (m_phase == 3), (m_phase == 3 && m_q.size() > 0));
            end
            if (m_phase == 3 && m_q.size() > 0) begin
                n_checks++;
                if (bus.rd_data !== m_q[0]) begin
                    n_errors++;
                    $display("FAIL random_data cycle %0d: rd_data=%h, required %h", i, bus.rd_data, m_q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_post_trigger();
        test_filter_priority();
        test_disruption();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
